mem_compact: RTL and testbench

Programmable in-place memory compaction engine. On a start command it sweeps a single-port memory of DEPTH signed words, tests each word against a selectable predicate, and rewrites the kept words contiguously from address 0 while preserving their order. It is the parametrised successor to the fixed keep-odd compactor. It adds a predicate mode, a signed threshold, configurable memory read latency, and a full-range kept count. It sits between the control sequencer and a synchronous single-port RAM.

---
 rtl/mem_compact.sv | 209 ++++++++++++++++++++
 tb/tb_mem_compact.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_compact.sv
// ---------------------------------------------------------------------------
// mem_compact
//
// Purpose:
//   In-place compaction engine for a synchronous single-port RAM.
//   A start command triggers a sweep over every word in address order.
//   Each word is tested against a selectable predicate.
//   Kept words are rewritten contiguously from address 0, preserving order.
//
//   The RAM is never read and written in the same cycle. The write pointer
//   never passes the read pointer, so a word is always read before its
//   address can be overwritten.
//
// Optional feature:
//   MEM_COMPACT_CLEAR_TAIL_EN -- when defined, a FILL phase runs after the
//   sweep and writes 0 to addresses o_count..DEPTH-1, one word per cycle.
//   When it is undefined, there is no FILL state and the tail keeps stale
//   data.
//
// Parameters:
//   DEPTH   number of RAM words (power of two, >= 4)
//   WIDTH   signed data width
//   RD_LAT  RAM read latency in cycles (1..3)
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset
//   i_start   start pulse, accepted only in IDLE or DONE
//   i_mode    predicate select: 0 keep odd, 1 keep even,
//             2 keep >= i_thresh, 3 keep < i_thresh
//   i_thresh  signed threshold for modes 2/3
//   o_rden    RAM read enable
//   o_wren    RAM write enable
//   o_addr    RAM address
//   i_data    RAM read data, valid RD_LAT cycles after o_rden
//   o_data    RAM write data
//   o_busy    high while a sweep (or tail fill) is in progress
//   o_done    high while in DONE
//   o_count   number of kept words; one bit wider than the pointers
// ---------------------------------------------------------------------------
module mem_compact #(
    parameter int DEPTH  = 32,
    parameter int WIDTH  = 8,
    parameter int RD_LAT = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [1:0]                 i_mode,
    input  logic signed [WIDTH-1:0]    i_thresh,
    output logic                       o_rden,
    output logic                       o_wren,
    output logic [$clog2(DEPTH)-1:0]   o_addr,
    input  logic signed [WIDTH-1:0]    i_data,
    output logic signed [WIDTH-1:0]    o_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    // WAIT lasts RD_LAT-1 cycles; the counter runs 0..RD_LAT-2.
    localparam logic [1:0]    WAIT_LAST  = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_CHECK,
`ifdef MEM_COMPACT_CLEAR_TAIL_EN
        S_FILL,
`endif
        S_DONE
    } state_t;

    state_t                    state_reg,  state_next;
    logic [AW-1:0]             rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]             wr_ptr_reg, wr_ptr_next;
    logic [AW:0]               count_reg,  count_next;
    logic [1:0]                mode_reg,   mode_next;
    logic signed [WIDTH-1:0]   thresh_reg, thresh_next;
    logic [1:0]                wait_reg,   wait_next;

    logic                      rd_en;
    logic                      wr_en;
    logic signed [WIDTH-1:0]   wr_data;
    logic                      keep;

    // Predicate on the word currently presented by the RAM. Modes 2/3 use
    // a signed WIDTH-bit compare against the threshold captured at start.
    always_comb begin
        keep = 1'b0;
        case (mode_reg)
            2'd0:    keep = i_data[0];
            2'd1:    keep = ~i_data[0];
            2'd2:    keep = (i_data >= thresh_reg);
            default: keep = (i_data < thresh_reg);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= S_IDLE;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            mode_reg   <= '0;
            thresh_reg <= '0;
            wait_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            mode_reg   <= mode_next;
            thresh_reg <= thresh_next;
            wait_reg   <= wait_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        mode_next   = mode_reg;
        thresh_next = thresh_reg;
        wait_next   = wait_reg;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_next  = S_READ;
                    mode_next   = i_mode;
                    thresh_next = i_thresh;
                    rd_ptr_next = '0;
                    wr_ptr_next = '0;
                    count_next  = '0;
                end
            end

            S_READ: begin
                rd_en      = 1'b1;
                wait_next  = '0;
                state_next = (RD_LAT == 1) ? S_CHECK : S_WAIT;
            end

            S_WAIT: begin
                if (wait_reg == WAIT_LAST) begin
                    state_next = S_CHECK;
                end else begin
                    wait_next = wait_reg + 2'd1;
                end
            end

            S_CHECK: begin
                if (keep) begin
                    wr_en       = 1'b1;
                    wr_data     = i_data;
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                    count_next  = count_reg + 1'b1;
                end
                rd_ptr_next = rd_ptr_reg + 1'b1;
                if (rd_ptr_reg == LAST_ADDR) begin
`ifdef MEM_COMPACT_CLEAR_TAIL_EN
                    // Nothing to clear when every word was kept; wr_ptr has
                    // wrapped to 0 in that case, so FILL must be skipped.
                    state_next = (count_next == FULL_COUNT) ? S_DONE : S_FILL;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    state_next = S_READ;
                end
            end

`ifdef MEM_COMPACT_CLEAR_TAIL_EN
            S_FILL: begin
                wr_en       = 1'b1;
                wr_data     = '0;
                wr_ptr_next = wr_ptr_reg + 1'b1;
                if (wr_ptr_reg == LAST_ADDR) begin
                    state_next = S_DONE;
                end
            end
`endif

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign o_rden  = rd_en;
    assign o_wren  = wr_en;
    // Writes target the compacted position; otherwise the address tracks
    // the read pointer.
    assign o_addr  = wr_en ? wr_ptr_reg : rd_ptr_reg;
    assign o_data  = wr_data;
    assign o_busy  = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign o_done  = (state_reg == S_DONE);
    assign o_count = count_reg;

endmodule

// File: tb/tb_mem_compact.sv
// ---------------------------------------------------------------------------
// tb_mem_compact
//
// Two engines run side by side, one with RD_LAT=1 and one with RD_LAT=3.
// Each engine has its own behavioural RAM, with a back-door load port used
// between sweeps. Expected RAM images are built by filtering a snapshot of
// the RAM through the predicate rules using plain integer arithmetic.
// MEM_COMPACT_CLEAR_TAIL_EN selects the tail behaviour, as in the design.
// ---------------------------------------------------------------------------
module tb_mem_compact;

    localparam int DEPTH = 32;
    localparam int WIDTH = 8;
    localparam int AW    = 5;
    localparam int NI    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst    [NI];
    logic                     start  [NI];
    logic [1:0]               mode   [NI];
    logic signed [WIDTH-1:0]  thresh [NI];
    logic                     rden   [NI];
    logic                     wren   [NI];
    logic [AW-1:0]            addr   [NI];
    logic signed [WIDTH-1:0]  rdata  [NI];
    logic signed [WIDTH-1:0]  wdata  [NI];
    logic                     busy   [NI];
    logic                     done   [NI];
    logic [AW:0]              count  [NI];

    logic signed [WIDTH-1:0]  mem  [NI][DEPTH];
    logic signed [WIDTH-1:0]  pipe [NI][3];

    logic                     ld_en;
    int                       ld_sel;
    logic [AW-1:0]            ld_addr;
    logic signed [WIDTH-1:0]  ld_data;

    int n_checks = 0;
    int n_errors = 0;

    logic signed [WIDTH-1:0]  img     [DEPTH];
    logic signed [WIDTH-1:0]  orig    [DEPTH];
    logic signed [WIDTH-1:0]  exp_mem [DEPTH];
    int                       exp_count;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            mem_compact #(
                .DEPTH (DEPTH),
                .WIDTH (WIDTH),
                .RD_LAT((gi == 0) ? 1 : 3)
            ) u_dut (
                .i_clk   (clk),
                .i_rst   (rst[gi]),
                .i_start (start[gi]),
                .i_mode  (mode[gi]),
                .i_thresh(thresh[gi]),
                .o_rden  (rden[gi]),
                .o_wren  (wren[gi]),
                .o_addr  (addr[gi]),
                .i_data  (rdata[gi]),
                .o_data  (wdata[gi]),
                .o_busy  (busy[gi]),
                .o_done  (done[gi]),
                .o_count (count[gi])
            );
        end
    endgenerate

    // Behavioural RAMs. Read data is shifted through a pipe so it appears
    // RD_LAT cycles after the read enable. Cycles without a read load a
    // filler value, so an early or late sample returns the wrong word.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (ld_en && ld_sel == k) begin
                mem[k][ld_addr] <= ld_data;
            end else if (wren[k]) begin
                mem[k][addr[k]] <= wdata[k];
            end
            pipe[k][0] <= rden[k] ? mem[k][addr[k]] : WIDTH'(8'h55);
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end
    assign rdata[0] = pipe[0][0];
    assign rdata[1] = pipe[1][2];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit keep_word(input int v, input int m, input int t);
        case (m)
            0:       return (v % 2) != 0;
            1:       return (v % 2) == 0;
            2:       return v >= t;
            default: return v < t;
        endcase
    endfunction

    task automatic build_expected(input int m, input int t);
        int kept[$];
        kept = {};
        for (int i = 0; i < DEPTH; i++) begin
            if (keep_word(int'(orig[i]), m, t)) kept.push_back(int'(orig[i]));
        end
        exp_count = kept.size();
        for (int i = 0; i < DEPTH; i++) begin
            if (i < exp_count) begin
                exp_mem[i] = WIDTH'(kept[i]);
            end else begin
`ifdef MEM_COMPACT_CLEAR_TAIL_EN
                exp_mem[i] = '0;
`else
                exp_mem[i] = orig[i];
`endif
            end
        end
    endtask

    task automatic load_img(input int k);
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            ld_en   = 1'b1;
            ld_sel  = k;
            ld_addr = AW'(i);
            ld_data = img[i];
        end
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic check_outputs_zero(input int k, input string tag);
        check({tag, "_rden"},  rden[k],  0);
        check({tag, "_wren"},  wren[k],  0);
        check({tag, "_addr"},  addr[k],  0);
        check({tag, "_data"},  wdata[k], 0);
        check({tag, "_busy"},  busy[k],  0);
        check({tag, "_done"},  done[k],  0);
        check({tag, "_count"}, count[k], 0);
    endtask

    // One full sweep. With disturb set, i_start is pulsed and i_mode /
    // i_thresh are changed while the sweep runs; the result must still
    // follow the original mode and threshold.
    task automatic run_sweep(input int k, input logic [1:0] m,
                             input logic signed [WIDTH-1:0] t,
                             input bit disturb, input string tag);
        int ncyc;
        int coll;
        int exp_cyc;
        bit finished;
        for (int i = 0; i < DEPTH; i++) orig[i] = mem[k][i];
        build_expected(int'(m), int'(t));
        @(posedge clk); #1;
        start[k]  = 1'b1;
        mode[k]   = m;
        thresh[k] = t;
        @(posedge clk); #1;
        start[k] = 1'b0;
        ncyc = 0;
        coll = 0;
        finished = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (done[k]) begin
                finished = 1'b1;
                break;
            end
            if (busy[k]) ncyc++;
            if (rden[k] && wren[k]) coll++;
            if (disturb && (c == 1 || c == 2 || c == 9)) begin
                start[k]  = 1'b1;
                mode[k]   = ~m;
                thresh[k] = ~t;
            end else begin
                start[k] = 1'b0;
            end
        end
        start[k] = 1'b0;
        exp_cyc = DEPTH * (lat_of(k) + 1);
`ifdef MEM_COMPACT_CLEAR_TAIL_EN
        if (exp_count < DEPTH) exp_cyc += DEPTH - exp_count;
`endif
        check({tag, "_finished"}, finished, 1);
        check({tag, "_busy_cycles"}, ncyc, exp_cyc);
        check({tag, "_rd_wr_overlap"}, coll, 0);
        check({tag, "_count"}, count[k], exp_count);
        check({tag, "_busy_in_done"}, busy[k], 0);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("%s_w%0d", tag, i), mem[k][i], exp_mem[i]);
        end
        $display("sweep %s: lat=%0d mode=%0d thresh=%0d count=%0d exp=%0d cycles=%0d",
                 tag, lat_of(k), m, t, count[k], exp_count, ncyc);
    endtask

    // Starts a mode-0 sweep and asserts reset during the CHECK of word 10.
    task automatic reset_mid(input int k, input string tag);
        int ncyc;
        int trig;
        bit hit;
        trig = 10 * (lat_of(k) + 1) + lat_of(k) + 1;
        @(posedge clk); #1;
        start[k] = 1'b1;
        mode[k]  = 2'd0;
        @(posedge clk); #1;
        start[k] = 1'b0;
        ncyc = 0;
        hit = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (busy[k]) ncyc++;
            if (ncyc == trig) begin
                hit = 1'b1;
                rst[k] = 1'b1;
                break;
            end
        end
        check({tag, "_reached_word10"}, hit, 1);
        @(negedge clk);
        check_outputs_zero(k, tag);
        rst[k] = 1'b0;
        $display("reset %s: asserted after %0d busy cycles", tag, ncyc);
    endtask

    initial begin
        ld_en   = 1'b0;
        ld_sel  = 0;
        ld_addr = '0;
        ld_data = '0;
        for (int k = 0; k < NI; k++) begin
            rst[k]    = 1'b1;
            start[k]  = 1'b0;
            mode[k]   = '0;
            thresh[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero(0, "reset_l1");
        check_outputs_zero(1, "reset_l3");
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Odd keep, ascending data, RD_LAT=1.
        for (int i = 0; i < DEPTH; i++) img[i] = WIDTH'(i);
        load_img(0);
        run_sweep(0, 2'd0, '0, 1'b0, "odd_l1");

        // Signed threshold modes.
        for (int i = 0; i < DEPTH; i++) img[i] = WIDTH'($urandom);
        img[0] = -8'sd4;
        img[1] = 8'sd5;
        img[2] = -8'sd1;
        img[3] = 8'sd0;
        img[4] = 8'sd7;
        load_img(0);
        run_sweep(0, 2'd2, 8'sd0, 1'b0, "thr_ge_0");
        load_img(0);
        run_sweep(0, 2'd3, -8'sd1, 1'b0, "thr_lt_m1");

        // Extremes: all even words, then keep-odd on the same RAM.
        for (int i = 0; i < DEPTH; i++) img[i] = WIDTH'($urandom & 32'hFE);
        load_img(0);
        run_sweep(0, 2'd1, '0, 1'b0, "all_kept");
        run_sweep(0, 2'd0, '0, 1'b0, "none_kept");

        // RD_LAT=3 on ascending data.
        for (int i = 0; i < DEPTH; i++) img[i] = WIDTH'(i);
        load_img(1);
        run_sweep(1, 2'd0, '0, 1'b0, "odd_l3");

        // Start pulses and mode changes mid-sweep, then a restart from DONE.
        load_img(1);
        run_sweep(1, 2'd0, '0, 1'b1, "disturb_l3");
        run_sweep(1, 2'd0, '0, 1'b0, "restart_l3");

        // Random data, modes and thresholds on both latencies.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) img[i] = WIDTH'($urandom);
            load_img(r % 2);
            run_sweep(r % 2, 2'($urandom_range(0, 3)), WIDTH'($urandom), 1'b0,
                      $sformatf("rand%0d", r));
        end

        // Reset during word 10, then a normal sweep over the partial result.
        for (int i = 0; i < DEPTH; i++) img[i] = WIDTH'(i);
        load_img(0);
        reset_mid(0, "rst_mid");
        run_sweep(0, 2'd2, 8'sd10, 1'b0, "after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
